// File: rtl/ysyx_23060124_pkg.sv
// Shared definitions for the ysyx_23060124 core: fetch FSM encoding,
// AXI response codes and the architectural reset PC.
package ysyx_23060124_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_DEC  = 3'd3,
        S_WB   = 3'd4
    } fetch_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    // Sequential PC advance; plain 32-bit modulo add, low bits untouched.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

    // Any response other than OKAY is reported to the IDU as a fetch fault.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060124_ifu_fetch_if.sv
// Bus bundle of the instruction fetch unit: AXI4-Lite read channel (AR/R)
// towards memory plus the valid/ready instruction handoff towards the IDU.
// Signal names keep the fetch unit's point of view (o_ = driven by fetch).
interface ysyx_23060124_ifu_fetch_if;

    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_fetch_err;

    // Fetch unit side.
    modport master (
        output o_araddr, o_arvalid, o_rready,
        output o_post_valid, o_inst, o_pc, o_fetch_err,
        input  i_arready, i_rdata, i_rresp, i_rvalid, i_post_ready
    );

    // Memory / IDU side.
    modport slave (
        input  o_araddr, o_arvalid, o_rready,
        input  o_post_valid, o_inst, o_pc, o_fetch_err,
        output i_arready, i_rdata, i_rresp, i_rvalid, i_post_ready
    );

endinterface

// File: rtl/ysyx_23060124_ifu_fetch.sv
// Instruction fetch unit of a multicycle core. Owns the architectural PC,
// issues one AXI4-Lite read per instruction, hands the word to the IDU and
// waits for the WBU commit before computing the next PC. Redirects from the
// WBU are captured in any state and applied at the next commit.
module ysyx_23060124_ifu_fetch
    import ysyx_23060124_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_pc_update,
    input  logic [31:0]                   i_pc_next,
    input  logic                          i_commit,
    ysyx_23060124_ifu_fetch_if.master     bus
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fetch_err_q, fetch_err_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        post_valid_q, post_valid_d;

    logic ar_fire_s;
    logic r_fire_s;
    logic post_fire_s;
    logic commit_fire_s;

    // Handshake strobes; the valid/ready flops mirror the state, so these
    // only fire in the state that owns the corresponding channel.
    assign ar_fire_s     = arvalid_q    && bus.i_arready;
    assign r_fire_s      = rready_q     && bus.i_rvalid;
    assign post_fire_s   = post_valid_q && bus.i_post_ready;
    assign commit_fire_s = (state_q == S_WB) && i_commit;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: every state lasts at least one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_AR;
            S_AR: begin
                if (ar_fire_s) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (r_fire_s) begin
                    state_d = S_DEC;
                end else begin
                    state_d = S_R;
                end
            end
            S_DEC: begin
                if (post_fire_s) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_DEC;
                end
            end
            S_WB: begin
                if (commit_fire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so the strobes are flops.
    always_comb begin
        arvalid_d    = (state_d == S_AR);
        rready_d     = (state_d == S_R);
        post_valid_d = (state_d == S_DEC);
    end

    // Output strobe registers; async reset drops them immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            post_valid_q <= 1'b0;
        end else begin
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            post_valid_q <= post_valid_d;
        end
    end

    // PC and redirect capture: a same-cycle redirect beats a pending one,
    // which beats the sequential step; commit consumes any pending redirect.
    always_comb begin
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        if (i_pc_update) begin
            redir_pc_d = i_pc_next;
        end else begin
            redir_pc_d = redir_pc_q;
        end
        if (commit_fire_s) begin
            redir_pend_d = 1'b0;
            if (i_pc_update) begin
                pc_d = i_pc_next;
            end else if (redir_pend_q) begin
                pc_d = redir_pc_q;
            end else begin
                pc_d = pc_advance(pc_q, PC_STEP);
            end
        end else if (i_pc_update) begin
            redir_pend_d = 1'b1;
        end else begin
            redir_pend_d = redir_pend_q;
        end
    end

    // PC and redirect registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
        end else begin
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    // Instruction buffer: captures the read beat, error responses included.
    always_comb begin
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        if (r_fire_s) begin
            inst_d      = bus.i_rdata;
            fetch_err_d = resp_is_error(bus.i_rresp);
        end else begin
            inst_d      = inst_q;
            fetch_err_d = fetch_err_q;
        end
    end

    // Instruction buffer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_q      <= 32'h0000_0000;
            fetch_err_q <= 1'b0;
        end else begin
            inst_q      <= inst_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.o_araddr     = pc_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_arvalid    = arvalid_q;
    assign bus.o_rready     = rready_q;
    assign bus.o_post_valid = post_valid_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu_fetch.sv
// Bench for the instruction fetch unit: AXI memory responder with random
// latency, IDU/WBU driver with random stalls and redirects, and a scoreboard
// holding the PC each fetch must come from.
module tb_ysyx_23060124_ifu_fetch;
    import ysyx_23060124_pkg::*;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_pc_update = 1'b0;
    logic [31:0] i_pc_next = 32'h0;
    logic        i_commit = 1'b0;

    ysyx_23060124_ifu_fetch_if bus();

    ysyx_23060124_ifu_fetch #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_pc_update (i_pc_update),
        .i_pc_next   (i_pc_next),
        .i_commit    (i_commit),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // scoreboard: PC of every fetch still to be delivered
    logic [31:0] exp_q[$];

    // architectural model
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;

    // memory model knobs
    bit          fast = 1'b1;
    int          ar_stall = 0;
    bit          ovr_valid = 1'b0;
    logic [31:0] ovr_addr = 32'h0;
    logic [31:0] ovr_data = 32'h0;
    logic [1:0]  ovr_resp = 2'b00;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (ovr_valid && a == ovr_addr) return ovr_data;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        if (ovr_valid && a == ovr_addr) return ovr_resp;
        return (a[5:2] == 4'hB) ? 2'b11 : 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int want);
        total++;
        bad++;
        $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    endtask

    task automatic pulse(input logic [31:0] tgt);
        i_pc_update = 1'b1;
        i_pc_next   = tgt;
        m_pend      = 1'b1;
        m_pend_pc   = tgt;
    endtask

    // AXI memory: accepts AR, answers with R after 0..3 cycles
    initial begin
        bit          ar_fire, r_fire, rd_pend;
        logic [31:0] ar_addr, rd_addr;
        int          rd_wait;
        ar_fire = 0; r_fire = 0; rd_pend = 0; ar_addr = 0; rd_addr = 0; rd_wait = 0;
        bus.i_arready = 1'b0; bus.i_rvalid = 1'b0; bus.i_rdata = 32'h0; bus.i_rresp = 2'b00;
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.i_arready = 1'b0; bus.i_rvalid = 1'b0;
                rd_pend = 0; ar_fire = 0; r_fire = 0;
            end else begin
                if (r_fire) begin
                    bus.i_rvalid = 1'b0;
                    rd_pend = 0;
                end
                if (ar_fire) begin
                    rd_pend = 1;
                    rd_addr = ar_addr;
                    rd_wait = fast ? 0 : $urandom_range(0, 3);
                end
                if (ar_stall > 0) begin
                    bus.i_arready = 1'b0;
                    if (bus.o_arvalid) ar_stall--;
                end else begin
                    bus.i_arready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                if (rd_pend && !bus.i_rvalid) begin
                    if (rd_wait == 0) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = mem_data(rd_addr);
                        bus.i_rresp  = mem_resp(rd_addr);
                    end else begin
                        rd_wait--;
                    end
                end
                ar_fire = bus.o_arvalid && bus.i_arready;
                ar_addr = bus.o_araddr;
                r_fire  = bus.o_rready && bus.i_rvalid;
            end
        end
    end

    // monitor: stability under backpressure, AR address, delivered instruction
    initial begin
        bit          ar_hold, post_hold, h_err;
        logic [31:0] ar_hold_addr, h_inst, h_pc, p;
        ar_hold = 0; post_hold = 0; h_err = 0; ar_hold_addr = 0; h_inst = 0; h_pc = 0; p = 0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                ar_hold = 0;
                post_hold = 0;
            end else begin
                if (ar_hold) begin
                    check("ar_hold_valid", 32'(bus.o_arvalid), 32'd1);
                    check("ar_hold_addr", bus.o_araddr, ar_hold_addr);
                end
                if (post_hold) begin
                    check("dec_hold_valid", 32'(bus.o_post_valid), 32'd1);
                    check("dec_hold_inst", bus.o_inst, h_inst);
                    check("dec_hold_pc", bus.o_pc, h_pc);
                    check("dec_hold_err", 32'(bus.o_fetch_err), 32'(h_err));
                    check("dec_no_ar", 32'(bus.o_arvalid), 32'd0);
                end
                ar_hold      = bus.o_arvalid && !bus.i_arready;
                ar_hold_addr = bus.o_araddr;
                post_hold    = bus.o_post_valid && !bus.i_post_ready;
                h_inst = bus.o_inst; h_pc = bus.o_pc; h_err = bus.o_fetch_err;
                if (bus.o_arvalid && bus.i_arready) begin
                    if (exp_q.size() == 0) fail_now("ar_unexpected", 1, 0);
                    else check("ar_addr", bus.o_araddr, exp_q[0]);
                end
                if (bus.o_post_valid && bus.i_post_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("post_unexpected", 1, 0);
                    end else begin
                        p = exp_q.pop_front();
                        check("post_pc", bus.o_pc, p);
                        check("post_inst", bus.o_inst, mem_data(p));
                        check("post_err", 32'(bus.o_fetch_err), 32'(mem_resp(p) != 2'b00));
                    end
                end
            end
        end
    end

    // one complete instruction: wait for handoff, optional WB delay, commit
    task automatic do_fetch(input int post_stall, input int wb_wait,
                            input bit redir_dec, input logic [31:0] dec_tgt,
                            input bit redir_same, input logic [31:0] same_tgt,
                            input bit noise);
        int cyc; int stall; bit fired; bit dec_done; logic [31:0] nxt;
        cyc = 0; stall = post_stall; fired = 0; dec_done = 0;
        while (!fired && cyc < 300) begin
            @(negedge clock);
            cyc++;
            i_commit = 1'b0;
            i_pc_update = 1'b0;
            if (bus.o_post_valid && stall > 0) begin
                bus.i_post_ready = 1'b0;
                stall--;
            end else if (bus.o_post_valid) begin
                bus.i_post_ready = 1'b1;
            end else begin
                bus.i_post_ready = 1'($urandom_range(0, 1));
            end
            if (redir_dec && bus.o_post_valid && !dec_done) begin
                pulse(dec_tgt);
                dec_done = 1;
            end else if (noise && $urandom_range(0, 5) == 0) begin
                pulse($urandom);
            end
            if (noise && $urandom_range(0, 7) == 0) i_commit = 1'b1;
            fired = bus.o_post_valid && bus.i_post_ready;
        end
        if (!fired) begin
            fail_now("post_timeout", cyc, 300);
            return;
        end
        repeat (wb_wait) begin
            @(negedge clock);
            i_commit = 1'b0;
            i_pc_update = 1'b0;
            bus.i_post_ready = 1'($urandom_range(0, 1));
            if (noise && $urandom_range(0, 3) == 0) pulse($urandom);
        end
        @(negedge clock);
        i_pc_update = 1'b0;
        bus.i_post_ready = 1'($urandom_range(0, 1));
        i_commit = 1'b1;
        if (redir_same) begin
            i_pc_update = 1'b1;
            i_pc_next = same_tgt;
            nxt = same_tgt;
        end else if (m_pend) begin
            nxt = m_pend_pc;
        end else begin
            nxt = m_pc + 32'd4;
        end
        m_pend = 1'b0;
        m_pc = nxt;
        exp_q.push_back(nxt);
    endtask

    initial begin
        int cyc;
        m_pc = RST_PC; m_pend = 1'b0; m_pend_pc = 32'h0;
        bus.i_post_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_araddr", bus.o_araddr, RST_PC);
        check("rst_pc", bus.o_pc, RST_PC);
        check("rst_arvalid", 32'(bus.o_arvalid), 32'd0);
        check("rst_rready", 32'(bus.o_rready), 32'd0);
        check("rst_post_valid", 32'(bus.o_post_valid), 32'd0);
        check("rst_inst", bus.o_inst, 32'd0);
        check("rst_fetch_err", 32'(bus.o_fetch_err), 32'd0);
        exp_q.push_back(RST_PC);
        #2 reset = 1'b0;

        // zero-wait memory: o_post_valid three cycles after reset
        cyc = 0;
        while (!bus.o_post_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check("first_valid_latency", 32'(cyc), 32'd3);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // redirect in the commit cycle
        do_fetch(0, 0, 1'b0, 32'h0, 1'b1, 32'h3000_0100, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // redirect during DEC, applied at the later commit, then sequential
        do_fetch(2, 1, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // backpressure on AR and on the IDU handoff
        fast = 1'b0;
        ar_stall = 5;
        do_fetch(4, 0, 1'b0, 32'h0, 1'b1, 32'h3000_0200, 1'b0);

        // error response for 3000_0200, OKAY for the following fetch
        ovr_valid = 1'b1; ovr_addr = 32'h3000_0200; ovr_data = 32'hDEAD_BEEF; ovr_resp = 2'b10;
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);

        // PC wrap and unaligned pass-through
        do_fetch(1, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 2, 1'b0, 32'h0, 1'b1, 32'h3000_0102, 1'b0);
        do_fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // randomized traffic with stray redirects and stray commits
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0,
                     ($urandom_range(0, 3) == 0), $urandom, 1'b1);
        end

        // asynchronous reset while waiting for the read data
        cyc = 0;
        do begin
            @(negedge clock);
            i_commit = 1'b0;
            i_pc_update = 1'b0;
            cyc++;
        end while (!bus.o_rready && cyc < 100);
        check("reach_r_state", 32'(bus.o_rready), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_arvalid", 32'(bus.o_arvalid), 32'd0);
        check("async_rready", 32'(bus.o_rready), 32'd0);
        check("async_post_valid", 32'(bus.o_post_valid), 32'd0);
        check("async_araddr", bus.o_araddr, RST_PC);
        exp_q.delete();
        m_pc = RST_PC; m_pend = 1'b0;
        exp_q.push_back(RST_PC);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (3) do_fetch(1, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        @(negedge clock);
        i_commit = 1'b0;
        i_pc_update = 1'b0;
        repeat (10) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
